// File: rtl/rtmq_alu_mc_if.sv
// Instruction/result bundle of the RTMQ multi-cycle ALU.
// Handshake: an instruction transfers on a rising clk edge where in_vld and
// in_rdy are both 1. The sender holds in_opc/in_rda/in_r0/in_r1/in_inv
// stable while in_vld is 1. in_rdy never depends on in_vld. out_vld is a
// one-cycle pulse with no back-pressure, and out_* read as zero when it is 0.
interface rtmq_alu_mc_if #(
   parameter int W_REG = 32,
   parameter int W_ADR = 8
);
   logic             in_vld;
   logic             in_rdy;
   logic [3:0]       in_opc;
   logic [W_ADR-1:0] in_rda;
   logic [W_REG-1:0] in_r0;
   logic [W_REG-1:0] in_r1;
   logic             in_inv;
   logic             out_vld;
   logic [W_REG-1:0] out_res;
   logic [W_REG-1:0] out_msk;
   logic [W_ADR-1:0] out_rda;
   logic             out_ovf;
   logic             busy;

   modport master (
      output in_vld, in_opc, in_rda, in_r0, in_r1, in_inv,
      input  in_rdy, out_vld, out_res, out_msk, out_rda, out_ovf, busy
   );

   modport slave (
      input  in_vld, in_opc, in_rda, in_r0, in_r1, in_inv,
      output in_rdy, out_vld, out_res, out_msk, out_rda, out_ovf, busy
   );
endinterface

// File: rtl/rtmq_alu_mc.sv
// RTMQ ALU: two-stage pipeline for single-cycle opcodes plus an iterative
// shift-add multiplier (one product bit per cycle) that stalls the input.
// Results leave as (res & mask, ~mask, rda) so the register file writes
// RD <= out_res | (RD & out_msk).
module rtmq_alu_mc #(
   parameter int W_REG  = 32,
   parameter int W_ADR  = 8,
   parameter int MUL_EN = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   rtmq_alu_mc_if.slave        bus,
   output logic [1:0]          mul_state
);
   localparam int SH = $clog2(W_REG);

   localparam logic [3:0] OP_ADD = 4'h0, OP_AND = 4'h1, OP_XOR = 4'h2, OP_CLU = 4'h3;
   localparam logic [3:0] OP_CLS = 4'h4, OP_CEQ = 4'h5, OP_SGN = 4'h6, OP_SNE = 4'h7;
   localparam logic [3:0] OP_SMK = 4'h8, OP_MOV = 4'h9, OP_SLL = 4'hA, OP_SLA = 4'hB;
   localparam logic [3:0] OP_SLC = 4'hC, OP_REV = 4'hD, OP_MUL = 4'hE, OP_MLH = 4'hF;

   localparam logic [SH-1:0] CNT_LAST = SH'(W_REG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_st_t;

   mul_st_t            state;
   logic               rdy_q;
   logic               busy_q;
   logic               accept;
   logic               in_is_mul;

   // stage 0: accepted single-cycle instruction
   logic               s0_vld;
   logic [3:0]         s0_opc;
   logic [W_ADR-1:0]   s0_rda;
   logic [W_REG-1:0]   s0_r0;
   logic [W_REG-1:0]   s0_r1;
   logic               s0_inv;

   // multiplier datapath: prod holds {partial high word, remaining multiplier bits}
   logic [W_REG-1:0]   mcand;
   logic [2*W_REG-1:0] prod;
   logic [SH-1:0]      cnt;
   logic               mul_hi;
   logic [W_ADR-1:0]   mul_rda;
   logic [W_REG:0]     mul_part;
   logic [W_REG-1:0]   mul_res;
   logic               mul_ovf;

   // single-cycle ALU result
   logic [W_REG-1:0]   alu_val;
   logic [W_REG-1:0]   alu_keep;
   logic               alu_ovf;
   logic               alu_wr;
   logic [W_REG-1:0]   add_sum;
   logic               add_ovf;
   logic               cmp_u;
   logic               cmp_s;
   logic [W_REG-1:0]   rev_r0;

   // shifter: left by s, or right by W_REG-s when r1 MSB is set
   logic [SH-1:0]      sh_s;
   logic               sh_left;
   logic [SH:0]        sh_amt;
   logic [W_REG-1:0]   sh_fill;
   logic [2*W_REG-1:0] sh_lv;
   logic [2*W_REG-1:0] sh_rv;
   logic [W_REG-1:0]   sh_res;

   // output registers
   logic               ovld_q;
   logic [W_REG-1:0]   ores_q;
   logic [W_REG-1:0]   omsk_q;
   logic [W_ADR-1:0]   orda_q;
   logic               oovf_q;

   // multiply opcodes only take the iterative path when the multiplier exists
   assign in_is_mul = (MUL_EN != 0) && (bus.in_opc[3:1] == 3'b111);
   assign accept    = bus.in_vld & rdy_q;

   // capture single-cycle instructions into stage 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_vld <= 1'b0;
         s0_opc <= '0;
         s0_rda <= '0;
         s0_r0  <= '0;
         s0_r1  <= '0;
         s0_inv <= 1'b0;
      end else begin
         s0_vld <= accept & ~in_is_mul;
         if (accept & ~in_is_mul) begin
            s0_opc <= bus.in_opc;
            s0_rda <= bus.in_rda;
            s0_r0  <= bus.in_r0;
            s0_r1  <= bus.in_r1;
            s0_inv <= bus.in_inv;
         end
      end
   end

   assign mul_part = {1'b0, prod[2*W_REG-1:W_REG]} + (prod[0] ? {1'b0, mcand} : '0);
   assign mul_res  = mul_hi ? prod[2*W_REG-1:W_REG] : prod[W_REG-1:0];
   assign mul_ovf  = ~mul_hi & (|prod[2*W_REG-1:W_REG]);

   // multiplier FSM; also owns in_rdy so the input stalls from accept to DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         mcand   <= '0;
         prod    <= '0;
         cnt     <= '0;
         mul_hi  <= 1'b0;
         mul_rda <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (accept && in_is_mul) begin
                  mcand   <= bus.in_r0;
                  prod    <= {{W_REG{1'b0}}, bus.in_r1};
                  cnt     <= '0;
                  mul_hi  <= bus.in_opc[0];
                  mul_rda <= bus.in_rda;
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               prod <= {mul_part, prod[W_REG-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  busy_q <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               rdy_q <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign add_sum = s0_r0 + s0_r1;
   assign add_ovf = (s0_r0[W_REG-1] == s0_r1[W_REG-1]) && (add_sum[W_REG-1] != s0_r0[W_REG-1]);
   assign cmp_u   = s0_r0 < s0_r1;
   assign cmp_s   = $signed(s0_r0) < $signed(s0_r1);

   assign sh_s    = s0_r1[SH-1:0];
   assign sh_left = ~s0_r1[W_REG-1];
   assign sh_amt  = (SH+1)'(W_REG) - {1'b0, sh_s};
   assign sh_lv   = {s0_r0, sh_fill} << sh_s;
   assign sh_rv   = {sh_fill, s0_r0} >> sh_amt;
   assign sh_res  = sh_left ? sh_lv[2*W_REG-1:W_REG] : sh_rv[W_REG-1:0];

   // bits shifted in: SLC recirculates r0, SLA sign-fills only on right shifts
   always_comb begin
      sh_fill = '0;
      case (s0_opc)
         OP_SLL:  sh_fill = {W_REG{s0_inv}};
         OP_SLC:  sh_fill = s0_r0;
         default: sh_fill = sh_left ? '0 : {W_REG{s0_r0[W_REG-1]}};
      endcase
   end

   // bit-order reversal of r0
   always_comb begin
      rev_r0 = '0;
      for (int i = 0; i < W_REG; i++) rev_r0[i] = s0_r0[W_REG-1-i];
   end

   // single-cycle opcode decode; MUL/MLH land here only without a multiplier
   always_comb begin
      alu_val  = '0;
      alu_keep = '1;
      alu_ovf  = 1'b0;
      alu_wr   = 1'b1;
      case (s0_opc)
         OP_ADD, OP_MUL, OP_MLH: begin
            alu_val = s0_inv ? -add_sum : add_sum;
            alu_ovf = add_ovf;
         end
         OP_AND: alu_val = s0_inv ? ~(s0_r0 & s0_r1) : (s0_r0 & s0_r1);
         OP_XOR: alu_val = s0_inv ? ~(s0_r0 ^ s0_r1) : (s0_r0 ^ s0_r1);
         OP_CLU: alu_val = {W_REG{cmp_u ^ s0_inv}};
         OP_CLS: alu_val = {W_REG{cmp_s ^ s0_inv}};
         OP_CEQ: alu_val = {W_REG{(s0_r0 == s0_r1) ^ s0_inv}};
         OP_SGN: alu_val = s0_r1[W_REG-1] ? -s0_r0 : s0_r0;
         OP_SNE: begin
            alu_val = s0_r0;
            if (!(s0_r1[W_REG-1] ^ s0_inv)) begin
               alu_keep = '0;
               alu_wr   = 1'b0;
            end
         end
         OP_SMK: begin
            alu_val  = s0_r0;
            alu_keep = s0_r1;
         end
         OP_MOV: alu_val = s0_inv ? ~s0_r1 : s0_r1;
         OP_SLL, OP_SLA, OP_SLC: alu_val = sh_res;
         OP_REV: alu_val = rev_r0;
         default: alu_val = '0;
      endcase
   end

   // result register: multiplier DONE and stage 0 never coincide because in_rdy is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovld_q <= 1'b0;
         ores_q <= '0;
         omsk_q <= '0;
         orda_q <= '0;
         oovf_q <= 1'b0;
      end else if (state == ST_DONE) begin
         ovld_q <= 1'b1;
         ores_q <= mul_res;
         omsk_q <= '0;
         orda_q <= mul_rda;
         oovf_q <= mul_ovf;
      end else if (s0_vld) begin
         ovld_q <= 1'b1;
         ores_q <= alu_val & alu_keep;
         omsk_q <= ~alu_keep;
         orda_q <= alu_wr ? s0_rda : '0;
         oovf_q <= alu_ovf;
      end else begin
         ovld_q <= 1'b0;
         ores_q <= '0;
         omsk_q <= '0;
         orda_q <= '0;
         oovf_q <= 1'b0;
      end
   end

   assign bus.in_rdy  = rdy_q;
   assign bus.busy    = busy_q;
   assign bus.out_vld = ovld_q;
   assign bus.out_res = ores_q;
   assign bus.out_msk = omsk_q;
   assign bus.out_rda = orda_q;
   assign bus.out_ovf = oovf_q;
   assign mul_state   = state;
endmodule

// File: doc/rtmq_alu_mc.md
RTMQ_ALU_MC -- requirements
Module: rtmq_alu_mc

Interface
REQ-001 Parameter W_REG, default 32, operand and result width; legal values are powers of two from 8 to 64.
REQ-002 Parameter W_ADR, default 8, destination register address width.
REQ-003 Parameter MUL_EN, default 1; 0 removes the multiplier, and opcodes MUL and MLH then behave as ADD.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  synchronous reset, active-low.
REQ-006 in_vld  in  1  instruction present.
REQ-007 in_rdy  out  1  block accepts instruction; transfer occurs when in_vld & in_rdy at a clock edge.
REQ-008 in_opc  in  4  opcode.
REQ-009 in_rda  in  W_ADR  destination address.
REQ-010 in_r0, in_r1  in  W_REG each  operand values, already resolved (immediate or register).
REQ-011 in_inv  in  1  RD inversion flag.
REQ-012 out_vld  out  1  result valid, one-cycle pulse.
REQ-013 out_res  out  W_REG  result ANDed with the mask.
REQ-014 out_msk  out  W_REG  inverted mask; the write rule is RD <= out_res | (RD & out_msk).
REQ-015 out_rda  out  W_ADR  destination address, aligned with out_res.
REQ-016 out_ovf  out  1  overflow flag, aligned with out_vld.
REQ-017 busy  out  1  multiplier iterating.

Function
REQ-018 Opcodes are 0 ADD, 1 AND, 2 XOR, 3 CLU, 4 CLS, 5 CEQ, 6 SGN, 7 SNE, 8 SMK, 9 MOV, A SLL, B SLA, C SLC, D REV, E MUL, F MLH.
REQ-019 ADD: result = (r0 + r1) mod 2^W_REG, then two's-complement negated if in_inv; out_ovf = signed overflow of r0 + r1.
REQ-020 AND and XOR: bitwise result, then bitwise inverted if in_inv.
REQ-021 CLU, CLS and CEQ: comparison r0<r1 unsigned, r0<r1 signed, and r0==r1 respectively.
- The compare bit is XORed with in_inv.
- The compare bit is replicated across all W_REG bits.
REQ-022 SGN: result = -r0 if r1[W_REG-1] is set, else r0.
REQ-023 SNE: result = r0, with mask all-ones if r1[W_REG-1]^in_inv is 1.
- Otherwise mask = 0 and out_rda = 0 (no write).
- out_vld still pulses in both cases.
REQ-024 SMK: result = r0, mask = r1.
REQ-025 MOV: result = r1, bitwise inverted if in_inv.
REQ-026 Shifts use shift amount s = r1[log2(W_REG)-1:0].
- r1 MSB = 0: shift left by s.
- r1 MSB = 1: shift right by W_REG-s.
REQ-027 Shift fill rules:
- SLL: zero fill, or one fill if in_inv.
- SLA: right shifts fill with r0 MSB; left shifts zero fill.
- SLC: rotate.
REQ-028 REV: bit-order reverse of r0.
REQ-029 MUL and MLH: unsigned W_REG x W_REG product, computed by an iterative shift-add of one bit per cycle.
- MUL returns the low word, with out_ovf = (high word != 0).
- MLH returns the high word, with out_ovf = 0.
REQ-030 All opcodes other than SNE and SMK use an all-ones mask; out_ovf = 0 unless stated otherwise.
REQ-031 Non-multiply latency: an instruction accepted at edge N produces out_vld at edge N+2.
- The pipeline is fully pipelined: one instruction per cycle.
REQ-032 Multiply state machine has states IDLE, RUN and DONE.
- IDLE to RUN on acceptance of MUL or MLH.
- RUN lasts W_REG cycles.
- DONE lasts one cycle, with out_vld and the result registered out, then returns to IDLE.
- Multiply latency is W_REG+2 edges.
REQ-033 in_rdy = 0 from the edge accepting MUL or MLH until the DONE edge; in_rdy = 1 otherwise.
- busy = 1 in RUN.
REQ-034 In-flight non-multiply results accepted before a multiply still emerge in order; a multiply result never coincides with another out_vld.
REQ-035 When out_vld = 0: out_res = 0, out_msk = 0, out_rda = 0, out_ovf = 0.
REQ-036 If in_vld = 0 or in_rdy = 0, no instruction enters the pipeline and no spurious out_vld is produced.

Reset
REQ-037 While rst_n = 0 at an edge, the following hold:
- All pipeline registers clear.
- FSM goes to IDLE.
- out_vld, out_res, out_msk, out_rda, out_ovf and busy = 0.
- in_rdy = 0.
REQ-038 Reset asserted mid-multiply aborts the operation with no result emitted.
- in_rdy = 1 on the first edge after rst_n returns to 1.

Verification
REQ-039 ADD, W_REG=32: r0=0x7FFFFFFF, r1=1, inv=0 -> edge N+2 gives out_res=0x80000000, out_ovf=1, out_msk=0.
REQ-040 SNE: r0=5, r1=0x80000000, inv=1 -> out_rda=0, out_msk=0xFFFFFFFF, out_res=0; with inv=0 -> out_res=5, out_rda=in_rda.
REQ-041 MUL: r0=0x10000, r1=0x10000 -> in_rdy low for 33 cycles, then out_res=0 with out_ovf=1; MLH with the same operands -> out_res=1.
REQ-042 Back-to-back stream: ADD, XOR, MUL, AND, one per cycle -> results arrive in order; AND is accepted only after MUL's DONE.
REQ-043 Shifts: SLA r0=0x80000000, r1=0xFFFFFFFC (right shift 4) -> 0xF8000000; SLC r0=0x80000001, r1=1 -> 0x00000003.
REQ-044 rst_n pulsed low at RUN cycle 10 -> no out_vld appears; a new ADD 2+3 gives 5 at N+2.
